// File: rtl/instr_issue_seq.sv
// Fetch/issue sequencer: reads opcode/operand pairs from the program ROM and issues one bus command per instruction.
// Optional ISSUE_RETIRE_COUNT_EN adds a 16-bit retired-instruction counter output.
module instr_issue_seq #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ROM_AW     = 8,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  read_enable,
    output logic                  write_enable,
    output logic [ROM_AW-1:0]     pc,
`ifdef ISSUE_RETIRE_COUNT_EN
    output logic [15:0]           retired_count,
`endif
    output logic                  busy,
    output logic                  halted
);

    localparam logic [3:0] CLS_RAM  = 4'h4;
    localparam logic [3:0] CLS_ROM  = 4'h3;
    localparam logic [3:0] CLS_REG  = 4'h9;
    localparam logic [3:0] CLS_PC   = 4'h7;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ROM_AW-1:0]     r_pc;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0] r_operand;

    logic [3:0]            w_cls;
    logic [3:0]            w_op;
    logic                  w_mem_class;
    logic                  w_is_pc;
    logic                  w_is_halt;
    logic                  w_wr_cmd;
    logic                  w_rd_cmd;

    assign w_cls       = r_opcode[DATA_WIDTH-1 -: 4];
    assign w_op        = r_opcode[DATA_WIDTH-5 -: 4];
    assign w_mem_class = (w_cls == CLS_RAM) || (w_cls == CLS_ROM) || (w_cls == CLS_REG);
    assign w_is_pc     = (w_cls == CLS_PC);
    assign w_is_halt   = (r_opcode == HALT_WORD);
    assign w_wr_cmd    = w_mem_class && (w_op == OP_WRITE) && !w_is_halt;
    assign w_rd_cmd    = ((w_mem_class && (w_op == OP_READ)) || w_is_pc) && !w_is_halt;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: assign a default first so no path through the case leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (run) w_next_state = S_F0;
            S_F0:    w_next_state = S_F1;
            S_F1:    w_next_state = S_F2;
            S_F2:    w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_is_halt)  w_next_state = S_HALT;
                else if (run)   w_next_state = S_F0;
                else            w_next_state = S_IDLE;
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand word sits one address past the opcode; the ROM answers one cycle after the address.
    always_comb begin
        rom_addr     = r_pc;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b1;
        halted       = 1'b0;
        case (r_state)
            S_IDLE: busy = 1'b0;
            S_F1:   rom_addr = r_pc + ROM_AW'(1);
            S_EXEC: begin
                read_enable  = w_rd_cmd;
                write_enable = w_wr_cmd;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc      <= '0;
            r_opcode  <= '0;
            r_operand <= '0;
        end else begin
            case (r_state)
                S_F1: r_opcode  <= rom_data;
                S_F2: r_operand <= rom_data;
                S_EXEC: begin
                    if (w_is_halt)    r_pc <= r_pc;
                    else if (w_is_pc) r_pc <= bus_data[ROM_AW-1:0];
                    else              r_pc <= r_pc + ROM_AW'(2);
                end
                default: ;
            endcase
        end
    end

`ifdef ISSUE_RETIRE_COUNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (r_state == S_EXEC) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired_count = r_retired;
`endif

    assign pc      = r_pc;
    assign opcode  = r_opcode;
    assign operand = r_operand;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Scoreboard bench for instr_issue_seq: an instruction-level model queues per-cycle expectations, a monitor compares.
// Define ISSUE_RETIRE_COUNT_EN to also check retired_count.
module tb_instr_issue_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] bus_data;
    logic [15:0] opcode;
    logic [15:0] operand;
    logic        read_enable;
    logic        write_enable;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
`ifdef ISSUE_RETIRE_COUNT_EN
    logic [15:0] retired_count;
`endif

    instr_issue_seq dut (
        .clk          (clk),
        .reset        (rst_n),
        .run          (run),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .bus_data     (bus_data),
        .opcode       (opcode),
        .operand      (operand),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .pc           (pc),
`ifdef ISSUE_RETIRE_COUNT_EN
        .retired_count(retired_count),
`endif
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data appears one cycle after the address.
    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        bit          chk_addr;
        logic [7:0]  addr;
        logic [15:0] op;
        logic [15:0] opd;
        logic        re;
        logic        we;
        logic [7:0]  pc;
        logic        busy;
        logic        halted;
        logic [15:0] ret;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Architectural model state: what the spec says the sequencer holds between instructions.
    logic [7:0]  m_pc;
    logic [15:0] m_op;
    logic [15:0] m_opd;
    logic [15:0] m_ret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_addr) check("rom_addr", 32'(rom_addr), 32'(mon_e.addr));
            check("opcode",       32'(opcode),       32'(mon_e.op));
            check("operand",      32'(operand),      32'(mon_e.opd));
            check("read_enable",  32'(read_enable),  32'(mon_e.re));
            check("write_enable", 32'(write_enable), 32'(mon_e.we));
            check("pc",           32'(pc),           32'(mon_e.pc));
            check("busy",         32'(busy),         32'(mon_e.busy));
            check("halted",       32'(halted),       32'(mon_e.halted));
`ifdef ISSUE_RETIRE_COUNT_EN
            check("retired_count", 32'(retired_count), 32'(mon_e.ret));
`endif
        end
    end

    function automatic exp_t mk(bit ca, logic [7:0] a, logic [15:0] o, logic [15:0] d,
                                logic re, logic we, logic [7:0] p, logic b, logic h);
        exp_t e;
        e.chk_addr = ca; e.addr = a; e.op = o; e.opd = d; e.re = re; e.we = we;
        e.pc = p; e.busy = b; e.halted = h; e.ret = m_ret;
        return e;
    endfunction

    function automatic exp_t idle_rec();
        return mk(1'b0, 8'h00, m_op, m_opd, 1'b0, 1'b0, m_pc, 1'b0, 1'b0);
    endfunction

    function automatic exp_t halt_rec();
        return mk(1'b0, 8'h00, m_op, m_opd, 1'b0, 1'b0, m_pc, 1'b0, 1'b1);
    endfunction

    function automatic exp_t rst_rec();
        exp_t e;
        e = mk(1'b1, 8'h00, 16'h0, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        e.ret = 16'h0;
        return e;
    endfunction

    // One clock: record the state expected after this edge, then set inputs for the next edge.
    task automatic step(input exp_t e, input logic run_v, input logic [15:0] bus_v, input logic rst_n_v);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        run      = run_v;
        bus_data = bus_v;
        rst_n    = rst_n_v;
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_op = 16'h0; m_opd = 16'h0; m_ret = 16'h0;
    endtask

    // Caller has already applied reset for the next edge; n edges with reset low in total.
    task automatic reset_tail(input int n);
        model_reset();
        for (int i = 0; i < n - 1; i++) step(rst_rec(), 1'b1, 16'($urandom), 1'b0);
        step(rst_rec(), 1'b0, 16'($urandom), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(idle_rec(), 1'b0, 16'($urandom), 1'b1);
    endtask

    task automatic go();
        step(idle_rec(), 1'b1, 16'($urandom), 1'b1);
    endtask

    task automatic halt_wait(input int n);
        for (int i = 0; i < n; i++) step(halt_rec(), 1'b1, 16'($urandom), 1'b1);
    endtask

    // Issue the instruction at m_pc; run_exec is the run level at the closing edge of EXEC.
    task automatic issue(input logic run_f0, input logic run_f1, input logic run_f2,
                         input logic run_exec, input logic [15:0] bus_v, input bit rst_in_exec);
        logic [7:0]  a1;
        logic [15:0] nop, nopd;
        logic [3:0]  cls, op;
        logic        mem, is_pc, is_halt, re, we;
        a1      = m_pc + 8'd1;
        nop     = rom[m_pc];
        nopd    = rom[a1];
        cls     = nop[15:12];
        op      = nop[11:8];
        mem     = (cls == 4'h4) || (cls == 4'h3) || (cls == 4'h9);
        is_pc   = (cls == 4'h7);
        is_halt = (nop == 16'hFFFF);
        we      = !is_halt && mem && (op == 4'h1);
        re      = !is_halt && ((mem && (op == 4'h2)) || is_pc);
        step(mk(1'b1, m_pc, m_op, m_opd, 1'b0, 1'b0, m_pc, 1'b1, 1'b0), run_f0, 16'($urandom), 1'b1);
        step(mk(1'b1, a1,   m_op, m_opd, 1'b0, 1'b0, m_pc, 1'b1, 1'b0), run_f1, 16'($urandom), 1'b1);
        step(mk(1'b0, m_pc, nop,  m_opd, 1'b0, 1'b0, m_pc, 1'b1, 1'b0), run_f2, 16'($urandom), 1'b1);
        step(mk(1'b0, m_pc, nop,  nopd,  re,   we,   m_pc, 1'b1, 1'b0), run_exec, bus_v, !rst_in_exec);
        if (!rst_in_exec) begin
            m_op  = nop;
            m_opd = nopd;
            m_ret = m_ret + 16'd1;
            if (is_halt)    m_pc = m_pc;
            else if (is_pc) m_pc = bus_v[7:0];
            else            m_pc = m_pc + 8'd2;
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0]  c, o;
        logic [15:0] w;
        case ($urandom_range(0, 5))
            0: c = 4'h4;
            1: c = 4'h3;
            2: c = 4'h9;
            3: c = 4'h7;
            4: c = 4'h0;
            default: c = 4'($urandom);
        endcase
        case ($urandom_range(0, 2))
            0: o = 4'h1;
            1: o = 4'h2;
            default: o = 4'($urandom);
        endcase
        w = {c, o, 8'($urandom)};
        if (w == 16'hFFFF) w = 16'h0000;
        return w;
    endfunction

    initial begin
        logic run_exec;
        rst_n    = 1'b0;
        run      = 1'b1;
        bus_data = 16'h0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0;
        rom[8'h00] = 16'h4105; rom[8'h01] = 16'h00AB;
        rom[8'h02] = 16'h9203; rom[8'h03] = 16'h0010;
        rom[8'h04] = 16'h7000; rom[8'h05] = 16'h0020;
        rom[8'h42] = 16'h7000; rom[8'h43] = 16'h1234;
        rom[8'hFF] = 16'h3201;
        model_reset();

        // Reset held three edges with run=1, then released with run=0: stays idle.
        reset_tail(3);
        idle(3);

        // Write, read, PC jump to 0x40, NOP, truncated jump to 0xFF, wrap fetch with run dropped in F1.
        go();
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'hA5FF, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        idle(2);

        // Reset from idle, then reset landing during EXEC of a write.
        step(idle_rec(), 1'b0, 16'($urandom), 1'b0);
        reset_tail(1);
        go();
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1);
        reset_tail(1);
        idle(1);

        // NOP followed by HALT; run stays high while halted.
        rom[8'h00] = 16'h0000; rom[8'h01] = 16'h0000;
        rom[8'h02] = 16'hFFFF; rom[8'h03] = 16'h0000;
        go();
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        issue(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        halt_wait(10);
        step(halt_rec(), 1'b1, 16'($urandom), 1'b0);
        reset_tail(2);

        // Random program with random run gaps and random jump targets.
        for (int i = 0; i < 256; i++) rom[i] = rand_instr();
        idle(1);
        go();
        for (int i = 0; i < 250; i++) begin
            run_exec = (i != 249) && ($urandom_range(0, 3) != 0);
            issue(1'($urandom), 1'($urandom), 1'($urandom), run_exec, 16'($urandom), 1'b0);
            if (!run_exec) begin
                idle($urandom_range(0, 2));
                if (i != 249) go();
            end
        end
        idle(2);

        repeat (2) @(negedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_issue_seq.md
Name: instr_issue_seq

Overview:
- Fetch/issue sequencer directly upstream of the processor's 256x16 RAM block.
- Reads two-word instructions (opcode, operand) from the synchronous program ROM.
- Drives the shared opcode/operand/read_enable/write_enable bus seen by RAM, ROM-side and register/ALU stages for exactly one cycle per instruction.
- Owns the program counter, including jumps whose target is read back over the read_data bus (PC_OP).

Parameters:
- DATA_WIDTH, 16, width of opcode, operand and bus words.
- ROM_AW, 8, program ROM address width; pc width.
- HALT_WORD, 16'hFFFF, opcode value that stops the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
- run  in  1  level; 1 permits fetching of the next instruction.
- rom_addr  out  ROM_AW  program ROM address; ROM returns data one cycle later.
- rom_data  in  DATA_WIDTH  program ROM read data.
- bus_data  in  DATA_WIDTH  shared read_data bus (RAM output); sampled only for PC_OP.
- opcode  out  DATA_WIDTH  issued opcode (registered).
- operand  out  DATA_WIDTH  issued operand (registered).
- read_enable  out  1  bus read strobe.
- write_enable  out  1  bus write strobe.
- pc  out  ROM_AW  address of the current/next instruction's opcode word.
- busy  out  1  1 in any state except IDLE and HALT.
- halted  out  1  1 in HALT.

Behaviour:
- Reset:
  - state=IDLE, pc=0, opcode=0, operand=0.
  - read_enable=0, write_enable=0, rom_addr=0, busy=0, halted=0.
  - Reset takes effect from any state, including mid-fetch and EXEC.
  - Strobes are 0 in the cycle after the reset edge.
- Opcode fields: class=opcode[15:12], op=opcode[11:8].
  - Classes: RAM=4'h4, ROM=4'h3, REG=4'h9, PC=4'h7.
  - Ops: WRITE=4'h1, READ=4'h2.
- FSM, one transition per clk:
  - IDLE: run=1 -> F0; otherwise stay.
  - F0: rom_addr=pc -> F1.
  - F1: rom_addr=pc+1 (mod 2^ROM_AW); capture rom_data into opcode -> F2.
  - F2: capture rom_data into operand -> EXEC.
  - EXEC: lasts exactly one cycle.
    - Strobes are combinational from state and registered opcode, asserted only in EXEC.
    - write_enable=1 if class in {RAM, ROM, REG} and op==WRITE.
    - read_enable=1 if class in {RAM, ROM, REG} and op==READ, or class==PC.
    - Exit, PC class: pc <= bus_data[ROM_AW-1:0] (bus_data sampled at the closing edge of EXEC).
    - Exit, opcode==HALT_WORD: HALT, no strobes, pc unchanged.
    - Exit, otherwise: pc <= pc+2 (mod 2^ROM_AW).
    - Next state: F0 if run=1, else IDLE.
  - HALT: stays until reset; run ignored.
- Unrecognised class/op (including 16'h0000): no strobes, treated as a NOP, pc+=2.
- Throughput: 4 cycles per instruction when run stays high (F0, F1, F2, EXEC).
- opcode/operand hold their last values outside EXEC; consumers must qualify on the strobes.
- read_enable and write_enable are never high together.
- run dropping during F0–F2: the current instruction completes; the sequencer stops in IDLE after EXEC.
- Wrap: pc=8'hFF fetches its operand from address 8'h00; pc+2 from 8'hFE gives 8'h00.
- Jump target with bits above ROM_AW: truncated.
- Odd jump targets are legal; fetching proceeds from that address.

Optional Feature:
- Macro: ISSUE_RETIRE_COUNT_EN.
- Defined:
  - Adds output port retired_count, width 16.
  - Cleared on reset.
  - Increments by 1 at the closing edge of every EXEC, including NOPs and the halting instruction.
  - Wraps from 16'hFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with run=1 -> pc=0, strobes 0, busy=0; release reset with run=0 -> remains IDLE.
- Write issue: ROM[0]=16'h4105, ROM[1]=16'h00AB, run=1 -> 4th cycle after leaving IDLE shows opcode=4105, operand=00AB, write_enable=1 for exactly one cycle; pc=2 afterwards.
- Read then PC jump:
  - ROM[2..3]=9203/0010 -> read_enable one cycle with opcode=9203.
  - ROM[4..5]=7000/0020 with bus_data=16'h0040 during EXEC -> pc=8'h40, next rom_addr=8'h40.
- Halt and NOP: ROM[0..1]=0000/0000, ROM[2..3]=FFFF/0000 -> NOP with no strobes; then halted=1, busy=0, pc=2 held for 10 cycles despite run=1.
- Wrap/pause:
  - Jump to 8'hFF -> operand fetched at rom_addr 8'h00; next pc=8'h01.
  - Drop run during F1 -> EXEC completes, then IDLE.
- Mid-operation reset: assert reset=0 during EXEC of a write -> write_enable=0 the following cycle, state IDLE, pc=0. With ISSUE_RETIRE_COUNT_EN, retired_count=0.
